// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load-store unit (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_store;
  logic [2:0]  req_load;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_store, req_load, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_store, req_load, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with fixed request-to-response latency and byte/half/word lanes.
// Optional misaligned-access trapping is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state, w_state_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic [1:0]      r_store;
  logic [2:0]      r_load;
  logic            r_err;
  logic [31:0]     r_rd_word;
  logic [31:0]     r_mem [0:(1<<DEPTH_LOG2)-1];

  logic            w_accept;
  logic            w_enter_resp;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_wdata;
  logic            w_we;
  logic [1:0]      w_store;
  logic [2:0]      w_load;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [31:0]     w_wlane;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]     w_shift;
  logic [15:0]     w_half;
  logic [31:0]     w_load_data;
  logic            w_unused_addr;

  assign w_accept = (r_state == IDLE) && bus.req_valid;

  // With LATENCY=1 the commit happens on the accept edge, so operands come straight from the bus.
  assign w_addr  = w_accept ? bus.req_addr[AW-1:0] : r_addr;
  assign w_wdata = w_accept ? bus.req_wdata        : r_wdata;
  assign w_we    = w_accept ? bus.req_we           : r_we;
  assign w_store = w_accept ? bus.req_store        : r_store;
  assign w_load  = w_accept ? bus.req_load         : r_load;
  assign w_idx   = w_addr[AW-1:2];
  assign w_unused_addr = ^bus.req_addr[31:AW];

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_we) begin
      case (w_store)
        2'b10:   w_misalign = w_addr[0];
        2'b11:   w_misalign = |w_addr[1:0];
        default: w_misalign = 1'b0;
      endcase
    end else begin
      case (w_load)
        3'b000:         w_misalign = |w_addr[1:0];
        3'b011, 3'b100: w_misalign = w_addr[0];
        default:        w_misalign = 1'b0;
      endcase
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY > 1) begin
            w_state_next = WAIT;
            w_cnt_next   = 4'(LATENCY - 1);
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_store <= 2'b00;
      r_load  <= 3'b000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= bus.req_addr[AW-1:0];
        r_wdata <= bus.req_wdata;
        r_we    <= bus.req_we;
        r_store <= bus.req_store;
        r_load  <= bus.req_load;
        r_err   <= w_misalign;
      end
    end
  end

  // Store data is replicated across lanes; the byte enables pick the lane(s) actually written.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_be[gi] = (w_store == 2'b11) ||
                        ((w_store == 2'b10) && (w_addr[1] == 1'(gi / 2))) ||
                        ((w_store == 2'b01) && (w_addr[1:0] == 2'(gi)));
      assign w_wlane[8*gi +: 8] = (w_store == 2'b11) ? w_wdata[8*gi +: 8] :
                                  (w_store == 2'b10) ? w_wdata[8*(gi % 2) +: 8] :
                                                       w_wdata[7:0];
    end
  endgenerate

  // Reset blocks the commit so an in-flight store is dropped; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp) begin
      if (w_we && !w_misalign) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
      r_rd_word <= r_mem[w_idx];
    end
  end

  assign w_shift = r_rd_word >> {r_addr[1:0], 3'b000};
  assign w_half  = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  always_comb begin
    w_load_data = 32'd0;
    case (r_load)
      3'b000:  w_load_data = r_rd_word;
      3'b001:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b010:  w_load_data = {24'd0, w_shift[7:0]};
      3'b011:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {16'd0, w_half};
      default: w_load_data = 32'd0;
    endcase
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_err   = (r_state == RESP) && r_err;
  assign bus.rsp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_load_data : 32'd0;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder: lanes, sign extension, wrap, stall, reset abort, alignment.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  data_mem_responder_if dif ();

  data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (dif),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] st, input logic [2:0] ld);
    dif.req_valid = 1'b1;
    dif.req_we    = we;
    dif.req_addr  = addr;
    dif.req_wdata = wdata;
    dif.req_store = st;
    dif.req_load  = ld;
  endtask

  // Present one request, count negedges until rsp_valid, check payload, then retire it.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] st, input logic [2:0] ld,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(dif.req_ready), 32'd1);
    drive_req(we, addr, wdata, st, ld);
    @(posedge clk);
    @(negedge clk);
    dif.req_valid = 1'b0;
    n = 1;
    while (!dif.rsp_valid && n < 32) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd2);
    check({tag, " rdata"}, dif.rsp_rdata, exp_rdata);
    check({tag, " err"}, 32'(dif.rsp_err), 32'(exp_err));
    $display("[TB] %s we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d",
             tag, we, addr, wdata, dif.rsp_rdata, dif.rsp_err, n);
    dif.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.rsp_ready = 1'b0;
    check({tag, " retire"}, 32'(dif.rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int n;
    rst = 1'b1;
    dif.req_valid = 1'b0;
    dif.req_we    = 1'b0;
    dif.req_addr  = 32'd0;
    dif.req_wdata = 32'd0;
    dif.req_store = 2'b00;
    dif.req_load  = 3'b000;
    dif.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rsp_valid", 32'(dif.rsp_valid), 32'd0);
    check("reset rdata", dif.rsp_rdata, 32'd0);
    check("reset err", 32'(dif.rsp_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(dif.req_ready), 32'd1);
    $display("[TB] reset done");
    rst = 1'b0;

    xact("sw_10",   1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 3'b000, 32'h0,        1'b0);
    xact("lw_10",   1'b0, 32'h10, 32'h0,        2'b00, 3'b000, 32'hDEADBEEF, 1'b0);
    xact("sb_11",   1'b1, 32'h11, 32'h00000080, 2'b01, 3'b000, 32'h0,        1'b0);
    xact("lb_11",   1'b0, 32'h11, 32'h0,        2'b00, 3'b001, 32'hFFFFFF80, 1'b0);
    xact("lbu_11",  1'b0, 32'h11, 32'h0,        2'b00, 3'b010, 32'h00000080, 1'b0);
    xact("lw_10b",  1'b0, 32'h10, 32'h0,        2'b00, 3'b000, 32'hDEAD80EF, 1'b0);
    xact("ld101",   1'b0, 32'h10, 32'h0,        2'b00, 3'b101, 32'h0,        1'b0);
    xact("nop_st",  1'b1, 32'h10, 32'hFFFFFFFF, 2'b00, 3'b000, 32'h0,        1'b0);
    xact("lw_10c",  1'b0, 32'h10, 32'h0,        2'b00, 3'b000, 32'hDEAD80EF, 1'b0);
    xact("sw_20",   1'b1, 32'h20, 32'h00000000, 2'b11, 3'b000, 32'h0,        1'b0);
    xact("sh_22",   1'b1, 32'h22, 32'h00008001, 2'b10, 3'b000, 32'h0,        1'b0);
    xact("lh_22",   1'b0, 32'h22, 32'h0,        2'b00, 3'b011, 32'hFFFF8001, 1'b0);
    xact("lhu_22",  1'b0, 32'h22, 32'h0,        2'b00, 3'b100, 32'h00008001, 1'b0);
    xact("lw_422",  1'b0, 32'h420, 32'h0,       2'b00, 3'b000, 32'h80010000, 1'b0);

    // Stall: hold rsp_ready low while a store request is offered; it must be ignored.
    @(negedge clk);
    drive_req(1'b0, 32'h10, 32'h0, 2'b00, 3'b000);
    @(posedge clk);
    @(negedge clk);
    dif.req_valid = 1'b0;
    n = 1;
    while (!dif.rsp_valid && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("stall latency", 32'(n), 32'd2);
    held = dif.rsp_rdata;
    check("stall rdata", held, 32'hDEAD80EF);
    drive_req(1'b1, 32'h10, 32'hCAFEF00D, 2'b11, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall valid", 32'(dif.rsp_valid), 32'd1);
      check("stall hold", dif.rsp_rdata, held);
      check("stall req_ready", 32'(dif.req_ready), 32'd0);
      check("stall busy", 32'(busy), 32'd1);
    end
    $display("[TB] stall held rdata=0x%08h for 5 cycles", dif.rsp_rdata);
    dif.req_valid = 1'b0;
    dif.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.rsp_ready = 1'b0;
    check("stall retire valid", 32'(dif.rsp_valid), 32'd0);
    check("stall retire busy", 32'(busy), 32'd0);
    xact("lw_10d",  1'b0, 32'h10, 32'h0,        2'b00, 3'b000, 32'hDEAD80EF, 1'b0);

    // Reset during WAIT must drop the pending store.
    xact("sw_30",   1'b1, 32'h30, 32'h0BADF00D, 2'b11, 3'b000, 32'h0,        1'b0);
    @(negedge clk);
    drive_req(1'b1, 32'h30, 32'h12345678, 2'b11, 3'b000);
    @(posedge clk);
    @(negedge clk);
    dif.req_valid = 1'b0;
    check("abort busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort rsp_valid", 32'(dif.rsp_valid), 32'd0);
    check("abort busy idle", 32'(busy), 32'd0);
    check("abort req_ready", 32'(dif.req_ready), 32'd1);
    @(negedge clk);
    check("abort stays idle", 32'(dif.rsp_valid), 32'd0);
    $display("[TB] reset during WAIT applied");
    xact("lw_30",   1'b0, 32'h30, 32'h0,        2'b00, 3'b000, 32'h0BADF00D, 1'b0);

    // Misaligned word store.
    xact("sw_31",   1'b1, 32'h31, 32'hA5A5A5A5, 2'b11, 3'b000, 32'h0,        ALIGN_EN);
    xact("lw_30b",  1'b0, 32'h30, 32'h0,        2'b00, 3'b000,
         ALIGN_EN ? 32'h0BADF00D : 32'hA5A5A5A5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
